demux_1_to_n_reg: RTL and testbench

- Registered 1-to-N demultiplexer. It is the distribution-side counterpart of the tree-based N-to-1 select mux.
- One input stream with a select index is steered into one of N per-lane holding registers. Each lane drains through its own valid/ready handshake.
- Sits between a shared producer and N independent consumers, for example a fan-out of a serialized bus back to per-channel sinks.

---
 rtl/demux_1_to_n_reg.sv | 107 ++++++++++
 tb/tb_demux_1_to_n_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_n_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : demux_1_to_n_reg
// Purpose  : Registered 1-to-N demultiplexer with a valid/ready handshake on
//            each output lane.
//            Define DEMUX_SEL_ERR_CNT_EN to add a saturating err_cnt output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module demux_1_to_n_reg #(
  parameter int N = 9,
  parameter int m = 4,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic [m-1:0]     in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*W-1:0]   out_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic             sel_err
`ifdef DEMUX_SEL_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  // One extra bit so that N == 2**m is representable and compares to all-ones.
  localparam logic [m:0] C_LANES = (m+1)'(N);

  logic [N-1:0]   w_hit;
  logic           w_sel_ok;
  logic           w_lane_free;
  logic           w_acc;

  logic [N-1:0]   out_valid_q, out_valid_d;
  logic [N*W-1:0] out_data_q,  out_data_d;
  logic           sel_err_q,   sel_err_d;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane_dec
      assign w_hit[gi] = (in_sel == m'(gi));
    end
  endgenerate

  // An out-of-range word is always accepted and dropped so the producer never stalls.
  always_comb begin
    w_sel_ok    = ({1'b0, in_sel} < C_LANES);
    w_lane_free = |(w_hit & (~out_valid_q | out_ready));
    in_ready    = w_sel_ok ? w_lane_free : 1'b1;
    w_acc       = in_valid & in_ready & w_sel_ok;
  end

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    for (int i = 0; i < N; i++) begin
      if (w_acc && w_hit[i]) begin
        out_valid_d[i]       = 1'b1;
        out_data_d[i*W +: W] = in_data;
      end
    end
    sel_err_d = in_valid & ~w_sel_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel_err   = sel_err_q;

`ifdef DEMUX_SEL_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sel_err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1_to_n_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_demux_1_to_n_reg
// Purpose  : Self-checking bench for demux_1_to_n_reg (N=9 and N=1 instances).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_demux_1_to_n_reg;

  localparam int N = 9;
  localparam int M = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic [W-1:0]   in_data = '0;
  logic [M-1:0]   in_sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '0;
  logic           sel_err;

  // Single-lane instance
  logic [W-1:0]   s_in_data = '0;
  logic [0:0]     s_in_sel = '0;
  logic           s_in_valid = 1'b0;
  logic           s_in_ready;
  logic [W-1:0]   s_out_data;
  logic [0:0]     s_out_valid;
  logic [0:0]     s_out_ready = '0;
  logic           s_sel_err;

`ifdef DEMUX_SEL_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [15:0] s_err_cnt;
`endif

  demux_1_to_n_reg #(.N(N), .m(M), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
`ifdef DEMUX_SEL_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  demux_1_to_n_reg #(.N(1), .m(1), .W(W)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_in_data), .in_sel(s_in_sel), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sel_err(s_sel_err)
`ifdef DEMUX_SEL_ERR_CNT_EN
    , .err_cnt(s_err_cnt)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-lane word holders, lanes indexed by plain integers.
  logic [N-1:0] m_valid;
  logic [W-1:0] m_data [N];
  logic         m_err;
  int           m_cnt;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_err;
  int           s_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= '0;
      for (int i = 0; i < N; i++) m_data[i] <= '0;
      m_err <= 1'b0;
      m_cnt <= 0;
      s_valid <= 1'b0;
      s_data <= '0;
      s_err <= 1'b0;
      s_cnt <= 0;
    end else begin
      int idx;
      idx = int'(in_sel);
      for (int i = 0; i < N; i++) if (m_valid[i] && out_ready[i]) m_valid[i] <= 1'b0;
      if (in_valid && idx < N && (!m_valid[idx] || out_ready[idx])) begin
        m_valid[idx] <= 1'b1;
        m_data[idx]  <= in_data;
      end
      m_err <= in_valid && idx >= N;
      if (in_valid && idx >= N && m_cnt < 65535) m_cnt <= m_cnt + 1;

      if (s_valid && s_out_ready[0]) s_valid <= 1'b0;
      if (s_in_valid && s_in_sel == 1'b0 && (!s_valid || s_out_ready[0])) begin
        s_valid <= 1'b1;
        s_data  <= s_in_data;
      end
      s_err <= s_in_valid && s_in_sel != 1'b0;
      if (s_in_valid && s_in_sel != 1'b0 && s_cnt < 65535) s_cnt <= s_cnt + 1;
    end
  end

  function automatic logic [N*W-1:0] model_data();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = m_data[i];
    return r;
  endfunction

  function automatic logic model_ready();
    int idx;
    idx = int'(in_sel);
    if (idx >= N) return 1'b1;
    return !m_valid[idx] || out_ready[idx];
  endfunction

  // Every cycle, on the falling edge, compare both instances against the model.
  always @(negedge clk) begin
    check("in_ready",    in_ready,    model_ready());
    check("out_valid",   out_valid,   m_valid);
    check("out_data",    out_data,    model_data());
    check("sel_err",     sel_err,     m_err);
    check("s_in_ready",  s_in_ready,  (s_in_sel != 1'b0) || !s_valid || s_out_ready[0]);
    check("s_out_valid", s_out_valid, s_valid);
    check("s_out_data",  s_out_data,  s_data);
    check("s_sel_err",   s_sel_err,   s_err);
`ifdef DEMUX_SEL_ERR_CNT_EN
    check("err_cnt",     err_cnt,     16'(m_cnt));
    check("s_err_cnt",   s_err_cnt,   16'(s_cnt));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst out_valid", out_valid, '0);
    check("rst out_data",  out_data,  '0);
    check("rst sel_err",   sel_err,   1'b0);
    rst_n = 1'b1;
    step();

    // 1: single word to lane 3, held with no consumer
    in_sel = 4'd3; in_data = 8'hA5; in_valid = 1'b1;
    #1 check("t1 in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("t1 out_valid", out_valid, 9'h008);
      check("t1 lane3", out_data[3*W +: W], 8'hA5);
      step();
    end

    // 2: full lane blocks only its own select
    in_sel = 4'd3; in_data = 8'h11; in_valid = 1'b1;
    #1 check("t2 in_ready full", in_ready, 1'b0);
    step();
    check("t2 lane3 kept", out_data[3*W +: W], 8'hA5);
    in_sel = 4'd5; in_data = 8'h22;
    #1 check("t2 in_ready lane5", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("t2 out_valid", out_valid, 9'h028);

    // 3: back-to-back on lane 8 with consumer always ready
    out_ready = 9'h100;
    for (int k = 1; k <= 4; k++) begin
      in_sel = 4'd8; in_data = 8'(k); in_valid = 1'b1;
      #1 check("t3 in_ready", in_ready, 1'b1);
      step();
      check("t3 lane8", out_data[8*W +: W], 8'(k));
      check("t3 valid8", out_valid[8], 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("t3 valid8 drop", out_valid[8], 1'b0);
    out_ready = '0;

    // 4: out-of-range select dropped with a sel_err pulse per word
    for (int k = 0; k < 3; k++) begin
      in_sel = 4'd12; in_data = 8'hEE; in_valid = 1'b1;
      #1 check("t4 in_ready", in_ready, 1'b1);
      step();
      check("t4 sel_err", sel_err, 1'b1);
      check("t4 out_valid", out_valid, 9'h028);
    end
    in_valid = 1'b0;
    step();
    check("t4 sel_err end", sel_err, 1'b0);
`ifdef DEMUX_SEL_ERR_CNT_EN
    check("t4 err_cnt", err_cnt, 16'd3);
`endif

    // 5: asynchronous reset mid-cycle with lanes occupied
    foreach (in_sel[b]) begin end
    for (int k = 0; k < 3; k++) begin
      in_sel = (k == 0) ? 4'd0 : (k == 1) ? 4'd4 : 4'd7;
      in_data = 8'h30 + 8'(k); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("t5 filled", out_valid, 9'h0B9);
    #2 rst_n = 1'b0;
    #1 check("t5 async valid", out_valid, '0);
    check("t5 async data", out_data, '0);
    step();
    #3 rst_n = 1'b1;
    step();
    in_sel = 4'd4; in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t5 lane4 valid", out_valid, 9'h010);
    check("t5 lane4 data", out_data[4*W +: W], 8'h5A);

    // 6: single-lane instance
    s_in_sel = 1'b0; s_in_data = 8'h77; s_in_valid = 1'b1;
    step();
    check("t6 s valid", s_out_valid, 1'b1);
    check("t6 s data", s_out_data, 8'h77);
    s_out_ready = 1'b1; s_in_sel = 1'b1; s_in_data = 8'h99;
    #1 check("t6 s in_ready", s_in_ready, 1'b1);
    step();
    s_in_valid = 1'b0;
    check("t6 s sel_err", s_sel_err, 1'b1);
    check("t6 s drained", s_out_valid, 1'b0);
    check("t6 s data held", s_out_data, 8'h77);
    s_out_ready = 1'b0;

    // Randomized traffic checked by the model every cycle
    for (int k = 0; k < 600; k++) begin
      step();
      in_valid    = 1'($urandom);
      in_sel      = 4'($urandom_range(0, 15));
      in_data     = 8'($urandom);
      out_ready   = 9'($urandom) & 9'($urandom);
      s_in_valid  = 1'($urandom);
      s_in_sel    = 1'($urandom_range(0, 3) == 0);
      s_in_data   = 8'($urandom);
      s_out_ready = 1'($urandom);
    end
    in_valid = 1'b0; s_in_valid = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
